// File: rtl/rioctrl_io_pkg.sv
// Shared definitions for the remote I/O chain scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and the phase counts that make up one transfer.
package rioctrl_io_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        LATCH = 3'd4
    } state_t;

    // Each chain bit takes SETUP, HIGH and LOW phases; a transfer ends with one LATCH phase.
    localparam int PHASES_PER_BIT = 3;
    localparam int LATCH_PHASES   = 1;

endpackage

// File: rtl/rioctrl_io_sched_if.sv
// Bundle of request, parallel data and serial chain signals of the I/O scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; a request made while busy is held one-deep inside the scheduler.
// Modports: master = requester/chain model side, slave = scheduler side.
interface rioctrl_io_sched_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data_out;
    logic             sin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_in;
    logic             sout;
    logic             sclk;
    logic             load;

    modport master (
        output start, data_out, sin,
        input  busy, done, data_in, sout, sclk, load
    );

    modport slave (
        input  start, data_out, sin,
        output busy, done, data_in, sout, sclk, load
    );
endinterface

// File: rtl/rioctrl_io_tick.sv
// Phase-tick divider: one-clk tick every DIVIDER enabled clk cycles.
// Latency: tick is combinational on the DIVIDER-th enabled cycle after clear.
// Backpressure: none; counting pauses while enable is low.
// Ports: clk, rst (async high), clear (restart phase), enable (count), tick (phase end).
module rioctrl_io_tick #(
    parameter int DIVIDER = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/rioctrl_io_sched.sv
// Remote I/O chain scheduler: shifts data_out to the output chain while capturing the input chain.
// Latency: done pulses (3*WIDTH+1)*DIVIDER clk cycles after the accepting cycle.
// Backpressure: start while busy is held in a one-deep pending flag; extra starts are dropped.
// Ports: clk, rst (async high), io (slave modport: start/data_out/sin in, busy/done/data_in/sout/sclk/load out).
module rioctrl_io_sched
    import rioctrl_io_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIVIDER = 100,
    parameter int REFRESH = 10000
) (
    input  logic              clk,
    input  logic              rst,
    rioctrl_io_sched_if.slave io
);
    localparam int IW = $clog2(WIDTH);
    localparam int RW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
    // Reloading with REFRESH-1 makes the idle gap between done and the next busy exactly REFRESH cycles.
    localparam int REFRESH_RELOAD = (REFRESH > 0) ? REFRESH - 1 : 0;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    sel;
    logic [WIDTH-1:0] shadow, capture, last_sent, data_in_q;
    logic [RW-1:0]    refresh_cnt;
    logic             pending, init_flag, busy_q, done_q;
    logic             tick, trigger, accept, last_bit, refresh_hit, latch_exit;
    logic             sclk_c, load_c, sout_c;

    rioctrl_io_tick #(.DIVIDER(DIVIDER)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state != IDLE),
        .tick   (tick)
    );

    assign refresh_hit = (REFRESH != 0) && (refresh_cnt == '0);
    assign trigger     = io.start || pending || refresh_hit || (io.data_out != last_sent) || init_flag;
    assign accept      = (state == IDLE) && trigger;
    assign last_bit    = (idx == IW'(WIDTH - 1));
    assign latch_exit  = (state == LATCH) && tick;
    // Output chain is filled MSB first.
    assign sel         = IW'(WIDTH - 1) - idx;

    always_comb begin
        state_nx = state;
        sclk_c   = 1'b0;
        load_c   = 1'b1;
        sout_c   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) state_nx = SETUP;
            end
            SETUP: begin
                sout_c = shadow[sel];
                if (tick) state_nx = HIGH;
            end
            HIGH: begin
                sout_c = shadow[sel];
                sclk_c = 1'b1;
                if (tick) state_nx = LOW;
            end
            LOW: begin
                sout_c = shadow[sel];
                if (tick) state_nx = last_bit ? LATCH : SETUP;
            end
            LATCH: begin
                load_c = 1'b0;
                if (tick) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            shadow      <= '0;
            capture     <= '0;
            last_sent   <= '0;
            data_in_q   <= '0;
            pending     <= 1'b0;
            init_flag   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            refresh_cnt <= RW'(REFRESH);
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            if (accept) begin
                shadow    <= io.data_out;
                idx       <= '0;
                busy_q    <= 1'b1;
                pending   <= 1'b0;
                init_flag <= 1'b0;
            end else if (state != IDLE && io.start) begin
                pending <= 1'b1;
            end
            if (state == IDLE && refresh_cnt != '0) begin
                refresh_cnt <= refresh_cnt - 1'b1;
            end
            if (state == SETUP && tick) begin
                capture[idx] <= io.sin;
            end
            if (state == LOW && tick && !last_bit) begin
                idx <= idx + 1'b1;
            end
            if (latch_exit) begin
                data_in_q   <= capture;
                last_sent   <= shadow;
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                refresh_cnt <= RW'(REFRESH_RELOAD);
            end
        end
    end

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.data_in = data_in_q;
    assign io.sclk    = sclk_c;
    assign io.load    = load_c;
    assign io.sout    = sout_c;
endmodule

// File: tb/tb_rioctrl_io_sched.sv
// Bench for rioctrl_io_sched: timeline model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_rioctrl_io_sched;
    import rioctrl_io_pkg::*;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int XFER = (PHASES_PER_BIT * W + LATCH_PHASES) * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rioctrl_io_sched_if #(.WIDTH(W)) ifc ();
    rioctrl_io_sched_if #(.WIDTH(W)) ifr ();

    rioctrl_io_sched #(.WIDTH(W), .DIVIDER(D), .REFRESH(0)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.slave)
    );

    rioctrl_io_sched #(.WIDTH(W), .DIVIDER(D), .REFRESH(20)) dut_r (
        .clk (clk),
        .rst (rst),
        .io  (ifr.slave)
    );

    int errors = 0;
    int checks = 0;
    int nprint = 0;
    int cyc    = 0;
    bit cmp_en = 0;
    bit r_fin  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n = 0;
        while (!ifc.done && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=no_done want=done within %0d cycles", nm, lim);
        end
    endtask

    // Timeline model: a transfer is an offset counter 1..XFER; outputs follow from the offset.
    int         m_off;
    logic [7:0] m_shadow, m_last, m_cap, m_data_in;
    bit         m_pend, m_init, m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_off = 0; m_shadow = 0; m_last = 0; m_cap = 0; m_data_in = 0;
            m_pend = 0; m_init = 1; m_done = 0;
        end else begin
            m_done = 0;
            if (m_off != 0) begin
                if (ifc.start) m_pend = 1;
                if (m_off <= 3 * W * D && m_off % D == 0 && ((m_off - 1) / D) % 3 == 0)
                    m_cap[((m_off - 1) / D) / 3] = ifc.sin;
                if (m_off == XFER) begin
                    m_off = 0; m_data_in = m_cap; m_last = m_shadow; m_done = 1;
                end else begin
                    m_off++;
                end
            end else if (ifc.start || m_pend || m_init || ifc.data_out != m_last) begin
                m_shadow = ifc.data_out; m_off = 1; m_pend = 0; m_init = 0;
            end
        end
    end

    int          p;
    logic        e_sclk, e_load, e_sout;
    logic [12:0] exp_v, act_v;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_sclk = 0; e_load = 1; e_sout = 0;
            if (m_off != 0) begin
                p = (m_off - 1) / D;
                if (p < 3 * W) begin
                    e_sclk = (p % 3 == 1);
                    e_sout = m_shadow[W - 1 - p / 3];
                end else begin
                    e_load = 0;
                end
            end
            exp_v = {m_off != 0, m_done, e_sclk, e_load, e_sout, m_data_in};
            act_v = {ifc.busy, ifc.done, ifc.sclk, ifc.load, ifc.sout, ifc.data_in};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (nprint < 20)
                    $display("FAIL model_cmp t=%0t got=%h want=%h (busy,done,sclk,load,sout,data_in)",
                             $time, act_v, exp_v);
                nprint++;
            end
        end
    end

    // Input chain driver and output chain recorder.
    logic [7:0] sin_pat   = 8'h3C;
    logic [7:0] sout_bits = 8'h00;
    int         nfall     = 0;
    int         done_cnt  = 0;
    bit         busy_q    = 0;
    bit         sclk_q    = 0;

    always @(negedge clk) begin
        if (ifc.busy && !busy_q) sout_bits = 8'h00;
        if (ifc.sclk && !sclk_q) sout_bits = {sout_bits[6:0], ifc.sout};
        if (!ifc.busy) nfall = 0;
        else if (sclk_q && !ifc.sclk) nfall++;
        ifc.sin = sin_pat[(nfall > 7) ? 7 : nfall];
        if (ifc.done) done_cnt++;
        busy_q = ifc.busy;
        sclk_q = ifc.sclk;
    end

    // Auto-refresh instance: idle gap and transfer length.
    initial begin : refr_mon
        int  d_edge, b_edge, gaps;
        bit  have_d, prev_b;
        gaps = 0; have_d = 0; prev_b = 0; d_edge = 0; b_edge = 0;
        @(negedge rst);
        for (int i = 0; i < 400 && gaps < 2; i++) begin
            @(negedge clk);
            if (ifr.busy && !prev_b) begin
                if (have_d) begin
                    chk("refresh_gap", cyc - d_edge, 20);
                    gaps++;
                    have_d = 0;
                end
                b_edge = cyc;
            end
            if (ifr.done) begin
                chk("refresh_xfer_len", cyc - b_edge, XFER);
                d_edge = cyc;
                have_d = 1;
            end
            prev_b = ifr.busy;
        end
        if (gaps < 2) begin
            checks++;
            errors++;
            $display("FAIL refresh_gap timeout got=%0d gaps want=2", gaps);
        end
        r_fin = 1;
    end

    initial begin : main
        int rel, base;
        bit found;
        rst = 1'b1;
        ifc.start = 0; ifc.data_out = 8'hA5;
        ifr.start = 0; ifr.data_out = 8'h00; ifr.sin = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_load", ifc.load, 1);
        chk("rst_sclk", ifc.sclk, 0);
        chk("rst_sout", ifc.sout, 0);
        chk("rst_data_in", ifc.data_in, 0);

        // Init transfer after release.
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        wait_done("init_done", 80);
        chk("init_latency", cyc - (rel + 1), 50);
        chk("init_sout_bits", sout_bits, 8'hA5);
        chk("init_data_in", ifc.data_in, 8'h3C);

        // Start plus three starts while busy: exactly one extra transfer.
        repeat (3) @(negedge clk);
        base = done_cnt;
        ifc.start = 1; @(negedge clk); ifc.start = 0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ifc.start = 1; @(negedge clk); ifc.start = 0;
            repeat (3) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        chk("pending_one_extra", done_cnt - base, 2);
        chk("pending_idle_busy", ifc.busy, 0);

        // data_out change mid-transfer.
        sin_pat = 8'h5A;
        ifc.data_out = 8'h00;
        repeat (20) @(negedge clk);
        ifc.data_out = 8'hFF;
        wait_done("shadow_done1", 80);
        chk("shadow_old_bits", sout_bits, 8'h00);
        chk("shadow_data_in", ifc.data_in, 8'h5A);
        @(negedge clk);
        chk("mismatch_retrigger", ifc.busy, 1);
        wait_done("shadow_done2", 80);
        chk("shadow_new_bits", sout_bits, 8'hFF);

        // Reset during HIGH of bit 4.
        repeat (3) @(negedge clk);
        ifc.start = 1; @(negedge clk); ifc.start = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ifc.sclk && nfall == 4) found = 1;
            else @(negedge clk);
        end
        chk("midrst_reach_high4", found, 1);
        chk("midrst_pre_sclk", ifc.sclk, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_sclk", ifc.sclk, 0);
        chk("midrst_load", ifc.load, 1);
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_data_in", ifc.data_in, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        wait_done("midrst_init_done", 80);
        chk("midrst_init_latency", cyc - (rel + 1), 50);
        chk("midrst_init_bits", sout_bits, 8'hFF);
        chk("midrst_init_data_in", ifc.data_in, 8'h5A);

        for (int i = 0; i < 1000 && !r_fin; i++) @(negedge clk);
        if (!r_fin) begin
            checks++;
            errors++;
            $display("FAIL refresh_monitor timeout got=running want=finished");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rioctrl_io_sched.md
RIOCTRL_IO_SCHED -- requirements
Module: rioctrl_io_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8: chain length in bits (2..64).
REQ-002 SHALL have parameter DIVIDER, default 100: clk cycles per phase tick (>=1).
REQ-003 SHALL have parameter REFRESH, default 10000: idle clk cycles before an automatic transfer; 0 disables auto-refresh.
REQ-004 SHALL have the following ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request, sampled every clk.
- data_out  input  WIDTH  parallel value to shift out to the chain.
- sin  input  1  serial data from the input chain.
- busy  output  1  high from transfer acceptance until done.
- done  output  1  one-clk pulse; data_in has been updated.
- data_in  output  WIDTH  inputs captured by the last completed transfer.
- sout  output  1  serial data to the output chain.
- sclk  output  1  chain shift clock.
- load  output  1  latch strobe, active-low, idles high.

Function
REQ-005 SHALL use FSM states IDLE, SETUP, HIGH, LOW, LATCH; every non-IDLE state SHALL last exactly DIVIDER clk cycles.
REQ-006 IDLE trigger SHALL be any of: start, pending flag, refresh expiry, data_out != last_sent, or init flag; simultaneous triggers SHALL start one transfer.
REQ-007 On trigger in IDLE: snapshot data_out to shadow, bit index=0, restart divider, busy=1, go to SETUP.
REQ-008 SETUP: sout=shadow[WIDTH-1-idx]; sample sin into capture[idx]; go to HIGH.
REQ-009 HIGH: sclk=1; go to LOW.
REQ-010 LOW: sclk=0; if idx==WIDTH-1 go to LATCH, else idx+1 and go to SETUP.
REQ-011 LATCH: load=0 for the state; on exit load=1, data_in=capture, last_sent=shadow, done=1 for one clk, busy=0, reload refresh counter, go to IDLE.
REQ-012 done SHALL assert exactly (3*WIDTH+1)*DIVIDER clk cycles after the trigger cycle.
REQ-013 start while busy SHALL set a one-deep pending flag; further starts SHALL not queue more; pending SHALL clear on acceptance.
REQ-014 data_out changes during a transfer SHALL NOT affect shadow; the mismatch SHALL trigger a new transfer after done.
REQ-015 Refresh counter SHALL count down only in IDLE; expiry at 0 SHALL trigger; with REFRESH=0 it SHALL never trigger.
REQ-016 Index and divider counters SHALL be sized by $clog2 and SHALL never wrap past WIDTH-1 or DIVIDER-1.

Reset
REQ-017 On rst: state=IDLE, sclk=0, load=1, sout=0, busy=0, done=0, data_in=0, last_sent=0, pending=0, refresh counter=REFRESH; effect SHALL be immediate, including mid-transfer.
REQ-018 The init flag SHALL set on reset and SHALL force one transfer in the first clk after rst deasserts.

Structure
REQ-019 State encodings and phase-count constants SHALL live in shared package rioctrl_io_pkg.
REQ-020 The phase-tick divider SHALL be sub-module rioctrl_io_tick, with inputs clear/enable and a one-clk tick output.

Verification (WIDTH=8, DIVIDER=2, REFRESH=0 unless stated)
REQ-021 Release rst with data_out=0xA5 and sin driven from a 0x3C pattern -> one transfer; done at cycle 50; sout bits 1,0,1,0,0,1,0,1; data_in=0x3C.
REQ-022 Pulse start three times while busy -> exactly one extra transfer after done; then busy=0.
REQ-023 Change data_out 0x00->0xFF mid-transfer -> current sout shows old shadow; a second transfer follows done and shifts 0xFF.
REQ-024 REFRESH=20, no stimulus -> transfers recur with 20 IDLE cycles between a done and the next busy rise.
REQ-025 Assert rst during HIGH at idx=4 -> same cycle sclk=0, load=1, busy=0, data_in=0; init transfer follows release.
